// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port valid/ready arbiter and sequencer for a one-cycle-latency word-wide BSRAM.
// Each access walks IDLE -> ISSUE (RAM strobe) -> DONE (ready pulse, read data passed through).
module ram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              ram_sel,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [1:0]        gnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [31:0]       cmd_wdata_q, cmd_wdata_d;
  logic [3:0]        cmd_wstrb_q, cmd_wstrb_d;
  logic              pick_m1;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_wstrb_d = cmd_wstrb_q;
    pick_m1     = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie, round-robin hands the grant to whichever port was not served last.
        if (m0_valid && m1_valid) pick_m1 = PRIO_FIXED ? 1'b0 : ~last_q;
        else                      pick_m1 = m1_valid;

        if (m0_valid || m1_valid) begin
          cmd_addr_d  = pick_m1 ? m1_addr  : m0_addr;
          cmd_wdata_d = pick_m1 ? m1_wdata : m0_wdata;
          cmd_wstrb_d = pick_m1 ? m1_wstrb : m0_wstrb;
          gnt_d       = pick_m1 ? 2'b10 : 2'b01;
          last_d      = pick_m1;
          state_d     = ISSUE;
        end
      end
      ISSUE: state_d = DONE;
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      last_q      <= 1'b1;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_wstrb_q <= cmd_wstrb_d;
    end
  end

  // Outputs decode straight from the state register, so reset clears them without waiting for a clock.
  assign ram_sel     = (state_q == ISSUE);
  assign ram_wen     = ram_sel ? cmd_wstrb_q : 4'b0000;
  assign ram_address = cmd_addr_q;
  assign ram_wdata   = cmd_wdata_q;
  assign gnt         = gnt_q;

  assign m0_ready = (state_q == DONE) && gnt_q[0];
  assign m1_ready = (state_q == DONE) && gnt_q[1];
  assign m0_rdata = m0_ready ? ram_rdata : 32'h0000_0000;
  assign m1_rdata = m1_ready ? ram_rdata : 32'h0000_0000;

endmodule
